// File: rtl/gcd_controller.sv
// Control FSM for the subtract-and-compare GCD datapath.
// Sequences operand load, compare/subtract iterations, result strobe and
// done/err reporting. Moore machine: every output decodes from state_reg only.
module gcd_controller #(
  parameter int CNT_W    = 8,
  parameter int MAX_ITER = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic gt,
  input  logic lt,
  input  logic eq,
  output logic asel,
  output logic bsel,
  output logic aload,
  output logic bload,
  output logic out_en,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CMP,
    S_SUB_A,
    S_SUB_B,
    S_OUT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             flags_onehot;

  // Exactly one compare flag must be set for the datapath to be trusted.
  assign flags_onehot = ({gt, lt, eq} == 3'b100) ||
                        ({gt, lt, eq} == 3'b010) ||
                        ({gt, lt, eq} == 3'b001);

  // State and iteration counter registers; reset abandons any run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and counter update; CMP checks legality, equality, then timeout.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_LOAD;
          cnt_next   = '0;
        end
      end
      S_LOAD: state_next = S_CMP;
      S_CMP: begin
        if (!flags_onehot)         state_next = S_ERR;
        else if (eq)               state_next = S_OUT;
        else if (cnt_reg == MAX_CNT) state_next = S_ERR;
        else if (gt)               state_next = S_SUB_A;
        else                       state_next = S_SUB_B;
      end
      S_SUB_A, S_SUB_B: begin
        // CMP already stops at MAX_CNT; the guard keeps the counter from wrapping.
        if (cnt_reg != MAX_CNT) cnt_next = cnt_reg + 1'b1;
        state_next = S_CMP;
      end
      S_OUT:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Moore output decode from the registered state only.
  always_comb begin
    asel   = 1'b0;
    bsel   = 1'b0;
    aload  = 1'b0;
    bload  = 1'b0;
    out_en = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    busy   = (state_reg != S_IDLE);
    case (state_reg)
      S_LOAD: begin
        asel  = 1'b1;
        bsel  = 1'b1;
        aload = 1'b1;
        bload = 1'b1;
      end
      S_SUB_A: aload  = 1'b1;
      S_SUB_B: bload  = 1'b1;
      S_OUT:   out_en = 1'b1;
      S_DONE:  done   = 1'b1;
      S_ERR:   err    = 1'b1;
      default: ;
    endcase
  end

endmodule
